// File: rtl/scan_config_loader.sv
// Scan-chain configuration loader: accepts bitstream words on a valid/ready stream and
// shifts them LSB-first into the tile chain. Optional readback via `CFG_READBACK_EN.
module scan_config_loader #(
   parameter int CHAIN_LEN = 1024,
   parameter int WORD_W    = 8
) (
   input  logic              PCLK,
   input  logic              RESET_N,
   input  logic              START,
   input  logic              ABORT,
   input  logic [WORD_W-1:0] IN_DATA,
   input  logic              IN_VALID,
   output logic              IN_READY,
   output logic              SE,
   output logic              SOUT,
   input  logic              SIN,
   output logic              BUSY,
   output logic              DONE,
   output logic [WORD_W-1:0] RB_DATA,
   output logic              RB_VALID
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int IDX_W = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] BITS_INIT  = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] WORDS_INIT = CNT_W'((CHAIN_LEN + WORD_W - 1) / WORD_W);
   localparam logic [IDX_W-1:0] WORD_BITS  = IDX_W'(WORD_W);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [WORD_W-1:0] sr_q, sr_d;
   logic [IDX_W-1:0]  sr_cnt_q, sr_cnt_d;
   logic [WORD_W-1:0] buf_q, buf_d;
   logic              buf_full_q, buf_full_d;
   logic              se_q, se_d;
   logic              sout_q, sout_d;
   logic              busy, in_ready, xfer, emit, start_ok;

   assign busy     = (state_q == ST_FILL) || (state_q == ST_SHIFT);
   assign in_ready = busy && !buf_full_q && (word_cnt_q != '0);
   assign xfer     = IN_VALID && in_ready;
   assign emit     = busy && (sr_cnt_q != '0) && (bit_cnt_q != '0);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      sr_d       = sr_q;
      sr_cnt_d   = sr_cnt_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      se_d       = 1'b0;
      sout_d     = sout_q;
      start_ok   = 1'b0;

      if (emit) begin
         se_d      = 1'b1;
         sout_d    = sr_q[0];
         sr_d      = sr_q >> 1;
         sr_cnt_d  = sr_cnt_q - IDX_W'(1);
         bit_cnt_d = bit_cnt_q - CNT_W'(1);
      end

      // Refill in the same cycle the last bit leaves, so a keeping-up source shifts gaplessly.
      if ((sr_cnt_d == '0) && buf_full_q) begin
         sr_d       = buf_q;
         sr_cnt_d   = WORD_BITS;
         buf_full_d = 1'b0;
      end

      if (xfer) begin
         word_cnt_d = word_cnt_q - CNT_W'(1);
         if (sr_cnt_d == '0) begin
            sr_d     = IN_DATA;
            sr_cnt_d = WORD_BITS;
         end else begin
            buf_d      = IN_DATA;
            buf_full_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               start_ok   = 1'b1;
               state_d    = ST_FILL;
               bit_cnt_d  = BITS_INIT;
               word_cnt_d = WORDS_INIT;
               sr_cnt_d   = '0;
               buf_full_d = 1'b0;
            end
         end
         default: begin
            // Leftover bits of the final word are dropped here.
            if (bit_cnt_q == '0) begin
               state_d    = ST_DONE;
               sr_cnt_d   = '0;
               buf_full_d = 1'b0;
            end else if (sr_cnt_d != '0) begin
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_FILL;
            end
         end
      endcase

      if (ABORT) begin
         state_d    = ST_IDLE;
         start_ok   = 1'b0;
         bit_cnt_d  = '0;
         word_cnt_d = '0;
         sr_cnt_d   = '0;
         buf_full_d = 1'b0;
         se_d       = 1'b0;
         sout_d     = 1'b0;
      end
   end

   always_ff @(posedge PCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         sr_cnt_q   <= '0;
         buf_full_q <= 1'b0;
         se_q       <= 1'b0;
         sout_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         sr_cnt_q   <= sr_cnt_d;
         buf_full_q <= buf_full_d;
         se_q       <= se_d;
         sout_q     <= sout_d;
      end
   end

   // Word storage is qualified by the counters above and needs no reset.
   always_ff @(posedge PCLK) begin
      sr_q  <= sr_d;
      buf_q <= buf_d;
   end

   assign IN_READY = in_ready;
   assign SE       = se_q;
   assign SOUT     = sout_q;
   assign BUSY     = busy;
   assign DONE     = (state_q == ST_DONE);

`ifdef CFG_READBACK_EN
   logic [WORD_W-1:0] rb_acc_q, rb_acc_d;
   logic [IDX_W-1:0]  rb_idx_q, rb_idx_d;
   logic [WORD_W-1:0] rb_data_q, rb_data_d;
   logic              rb_valid_q, rb_valid_d;
   logic              last_cyc;

   // The cycle carrying the final SE=1 is the one where the bit counter has already hit 0.
   assign last_cyc = busy && (bit_cnt_q == '0);

   always_comb begin
      rb_acc_d   = rb_acc_q;
      rb_idx_d   = rb_idx_q;
      rb_data_d  = rb_data_q;
      rb_valid_d = 1'b0;
      if (se_q) begin
         rb_acc_d = rb_acc_q | (WORD_W'(SIN) << rb_idx_q);
         rb_idx_d = rb_idx_q + IDX_W'(1);
         if ((rb_idx_d == WORD_BITS) || last_cyc) begin
            rb_data_d  = rb_acc_d;
            rb_valid_d = 1'b1;
            rb_acc_d   = '0;
            rb_idx_d   = '0;
         end
      end
      if (start_ok || ABORT) begin
         rb_acc_d = '0;
         rb_idx_d = '0;
      end
   end

   always_ff @(posedge PCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rb_acc_q   <= '0;
         rb_idx_q   <= '0;
         rb_data_q  <= '0;
         rb_valid_q <= 1'b0;
      end else begin
         rb_acc_q   <= rb_acc_d;
         rb_idx_q   <= rb_idx_d;
         rb_data_q  <= rb_data_d;
         rb_valid_q <= rb_valid_d;
      end
   end

   assign RB_DATA  = rb_data_q;
   assign RB_VALID = rb_valid_q;
`else
   logic unused_sin;
   logic unused_start_ok;
   assign unused_sin      = SIN;
   assign unused_start_ok = start_ok;
   assign RB_DATA         = '0;
   assign RB_VALID        = 1'b0;
`endif

endmodule

// File: tb/tb_scan_config_loader.sv
// Directed bench for scan_config_loader: a 16-bit chain instance with a chain model on
// SIN, and a 20-bit instance for the partial-final-word case.
module tb_scan_config_loader;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       a_start, a_abort, a_valid, a_ready, a_se, a_sout, a_sin, a_busy, a_done, a_rb_valid;
   logic [7:0] a_data, a_rb_data;
   logic       b_start, b_abort, b_valid, b_ready, b_se, b_sout, b_sin, b_busy, b_done, b_rb_valid;
   logic [7:0] b_data, b_rb_data;

   scan_config_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_a (
      .PCLK(clk), .RESET_N(rst_n), .START(a_start), .ABORT(a_abort),
      .IN_DATA(a_data), .IN_VALID(a_valid), .IN_READY(a_ready),
      .SE(a_se), .SOUT(a_sout), .SIN(a_sin), .BUSY(a_busy), .DONE(a_done),
      .RB_DATA(a_rb_data), .RB_VALID(a_rb_valid));

   scan_config_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_b (
      .PCLK(clk), .RESET_N(rst_n), .START(b_start), .ABORT(b_abort),
      .IN_DATA(b_data), .IN_VALID(b_valid), .IN_READY(b_ready),
      .SE(b_se), .SOUT(b_sout), .SIN(b_sin), .BUSY(b_busy), .DONE(b_done),
      .RB_DATA(b_rb_data), .RB_VALID(b_rb_valid));

   // External 16-bit chain: head takes SOUT, tail bit returns on SIN.
   logic [15:0] chain16;
   logic        preload;
   always @(posedge clk) begin
      if (preload)   chain16 <= 16'h1234;
      else if (a_se) chain16 <= {a_sout, chain16[15:1]};
   end
   assign a_sin = chain16[0];
   assign b_sin = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [7:0]  wq[8];
   int          nw;
   int          r_se, r_rise, r_gap, r_acc, r_first_xfer, r_first_se, r_last_se, r_first_done;
   int          r_rb_cnt;
   logic [7:0]  r_rb[4];
   logic [63:0] r_bits;
   bit          r_rb_any, r_timeout;

   task automatic run_load(input bit sel, input int stall, input int stop_se, input int maxcyc);
      int widx, wait_cnt;
      bit prev_se, finished, stopped, se, sout, dn, rbv, rdy, vld;
      logic [7:0] rbd;
      r_se = 0; r_rise = 0; r_gap = 0; r_acc = 0; r_first_xfer = -1; r_first_se = -1;
      r_last_se = -1; r_first_done = -1; r_rb_cnt = 0; r_bits = '0; r_rb_any = 0; r_timeout = 0;
      for (int i = 0; i < 4; i++) r_rb[i] = '0;
      @(negedge clk);
      if (sel) b_start = 1'b1; else a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0; b_start = 1'b0;
      widx = 0; wait_cnt = 0; prev_se = 0; finished = 0; stopped = 0;
      for (int cyc = 0; cyc < maxcyc && !finished && !stopped; cyc++) begin
         se   = sel ? b_se : a_se;
         sout = sel ? b_sout : a_sout;
         dn   = sel ? b_done : a_done;
         rbv  = sel ? b_rb_valid : a_rb_valid;
         rbd  = sel ? b_rb_data : a_rb_data;
         if (se) begin
            if (r_se < 64) r_bits[r_se] = sout;
            if (r_se == 0) r_first_se = cyc;
            r_last_se = cyc;
            r_se++;
            if (!prev_se) r_rise++;
         end else if (r_se > 0 && !dn) begin
            r_gap++;
         end
         prev_se = se;
         if (rbv) begin
            if (r_rb_cnt < 4) r_rb[r_rb_cnt] = rbd;
            r_rb_cnt++;
         end
         if (rbd != 8'h00) r_rb_any = 1;
         if (dn) begin
            finished = 1;
            r_first_done = cyc;
         end
         if (stop_se != 0 && r_se >= stop_se) stopped = 1;
         if (!finished && !stopped) begin
            if (wait_cnt > 0) begin
               vld = 0;
               wait_cnt--;
            end else begin
               vld = (widx < nw);
            end
            if (sel) begin
               b_valid = vld; if (vld) b_data = wq[widx];
            end else begin
               a_valid = vld; if (vld) a_data = wq[widx];
            end
            rdy = sel ? b_ready : a_ready;
            if (vld && rdy) begin
               if (widx == 0) r_first_xfer = cyc;
               widx++;
               r_acc++;
               wait_cnt = stall;
            end
            @(negedge clk);
         end
      end
      if (!finished && !stopped) r_timeout = 1;
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (a_se !== 1'b0 || a_sout !== 1'b0) begin errors++; $display("FAIL reset_a_se_sout got %b%b exp 00", a_se, a_sout); end
      checks++; if (a_ready !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL reset_a_ctl got %b%b%b exp 000", a_ready, a_busy, a_done); end
      checks++; if (a_rb_valid !== 1'b0 || a_rb_data !== 8'h00) begin errors++; $display("FAIL reset_a_rb got %b %h exp 0 00", a_rb_valid, a_rb_data); end
      checks++; if (b_se !== 1'b0 || b_ready !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL reset_b got %b%b%b%b exp 0000", b_se, b_ready, b_busy, b_done); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (a_busy !== 1'b0 || a_ready !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %b%b exp 00", a_busy, a_ready); end
   endtask

   task automatic test_basic_load;
      wq[0] = 8'hA5; wq[1] = 8'h3C; nw = 2;
      run_load(1'b0, 0, 0, 80);
      checks++; if (r_timeout) begin errors++; $display("FAIL basic_timeout got no DONE exp DONE"); end
      checks++; if (r_se != 16) begin errors++; $display("FAIL basic_se_count got %0d exp 16", r_se); end
      checks++; if (r_rise != 1) begin errors++; $display("FAIL basic_se_runs got %0d exp 1", r_rise); end
      checks++; if (r_bits[15:0] !== 16'h3CA5) begin errors++; $display("FAIL basic_sout got %h exp 3ca5", r_bits[15:0]); end
      checks++; if (r_acc != 2) begin errors++; $display("FAIL basic_words got %0d exp 2", r_acc); end
      checks++; if (r_first_xfer != 0 || r_first_se != 2) begin errors++; $display("FAIL basic_latency got xfer %0d se %0d exp 0 2", r_first_xfer, r_first_se); end
      checks++; if (r_last_se != 17 || r_first_done != 18) begin errors++; $display("FAIL basic_done_timing got last_se %0d done %0d exp 17 18", r_last_se, r_first_done); end
      checks++; if (a_busy !== 1'b0 || a_ready !== 1'b0) begin errors++; $display("FAIL basic_after_done got busy %b ready %b exp 0 0", a_busy, a_ready); end
      repeat (3) @(negedge clk);
      checks++; if (a_done !== 1'b1 || a_se !== 1'b0) begin errors++; $display("FAIL basic_done_held got done %b se %b exp 1 0", a_done, a_se); end
   endtask

   task automatic test_partial_word;
      wq[0] = 8'hFF; wq[1] = 8'h00; wq[2] = 8'h0F; wq[3] = 8'hAA; nw = 4;
      run_load(1'b1, 0, 0, 80);
      checks++; if (r_timeout) begin errors++; $display("FAIL partial_timeout got no DONE exp DONE"); end
      checks++; if (r_se != 20 || r_rise != 1) begin errors++; $display("FAIL partial_se got %0d runs %0d exp 20 1", r_se, r_rise); end
      checks++; if (r_bits[19:0] !== 20'hF00FF) begin errors++; $display("FAIL partial_sout got %h exp f00ff", r_bits[19:0]); end
      checks++; if (r_acc != 3) begin errors++; $display("FAIL partial_words got %0d exp 3", r_acc); end
      checks++; if (r_first_done != 22) begin errors++; $display("FAIL partial_done_cycle got %0d exp 22", r_first_done); end
      b_valid = 1'b1; b_data = 8'h55;
      @(negedge clk);
      checks++; if (b_ready !== 1'b0 || b_done !== 1'b1) begin errors++; $display("FAIL partial_no_more got ready %b done %b exp 0 1", b_ready, b_done); end
      b_valid = 1'b0;
   endtask

   task automatic test_source_stall;
      wq[0] = 8'h5A; wq[1] = 8'hC3; nw = 2;
      run_load(1'b0, 12, 0, 100);
      checks++; if (r_timeout) begin errors++; $display("FAIL stall_timeout got no DONE exp DONE"); end
      checks++; if (r_se != 16) begin errors++; $display("FAIL stall_se_count got %0d exp 16", r_se); end
      checks++; if (r_rise != 2 || r_gap != 5) begin errors++; $display("FAIL stall_gap got runs %0d gap %0d exp 2 5", r_rise, r_gap); end
      checks++; if (r_bits[15:0] !== 16'hC35A) begin errors++; $display("FAIL stall_sout got %h exp c35a", r_bits[15:0]); end
      checks++; if (r_first_done != 23) begin errors++; $display("FAIL stall_done_cycle got %0d exp 23", r_first_done); end
   endtask

   task automatic test_reset_mid_shift;
      wq[0] = 8'hA5; wq[1] = 8'h3C; nw = 2;
      run_load(1'b0, 0, 7, 80);
      checks++; if (r_se != 7 || a_busy !== 1'b1) begin errors++; $display("FAIL midreset_pre got se %0d busy %b exp 7 1", r_se, a_busy); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if (a_se !== 1'b0 || a_sout !== 1'b0 || a_ready !== 1'b0) begin errors++; $display("FAIL midreset_outs got %b%b%b exp 000", a_se, a_sout, a_ready); end
      checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_rb_valid !== 1'b0 || a_rb_data !== 8'h00) begin errors++; $display("FAIL midreset_ctl got %b%b%b %h exp 000 00", a_busy, a_done, a_rb_valid, a_rb_data); end
      @(negedge clk);
      rst_n = 1'b1;
      run_load(1'b0, 0, 0, 80);
      checks++; if (r_timeout || r_se != 16 || r_first_se != 2) begin errors++; $display("FAIL midreset_reload got se %0d first %0d exp 16 2", r_se, r_first_se); end
      checks++; if (r_bits[15:0] !== 16'h3CA5) begin errors++; $display("FAIL midreset_sout got %h exp 3ca5", r_bits[15:0]); end
   endtask

   task automatic test_abort_start;
      wq[0] = 8'h96; wq[1] = 8'h0F; nw = 2;
      run_load(1'b0, 0, 5, 80);
      a_abort = 1'b1; a_start = 1'b1;
      @(negedge clk);
      a_abort = 1'b0; a_start = 1'b0;
      checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_se !== 1'b0) begin errors++; $display("FAIL abort_state got busy %b done %b se %b exp 0 0 0", a_busy, a_done, a_se); end
      @(negedge clk);
      checks++; if (a_busy !== 1'b0 || a_ready !== 1'b0) begin errors++; $display("FAIL abort_idle got busy %b ready %b exp 0 0", a_busy, a_ready); end
      run_load(1'b0, 0, 0, 80);
      checks++; if (r_timeout || r_se != 16 || r_rise != 1) begin errors++; $display("FAIL abort_reload got se %0d runs %0d exp 16 1", r_se, r_rise); end
      checks++; if (r_bits[15:0] !== 16'h0F96) begin errors++; $display("FAIL abort_sout got %h exp 0f96", r_bits[15:0]); end
   endtask

   task automatic test_readback;
      @(negedge clk);
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      wq[0] = 8'hA5; wq[1] = 8'h3C; nw = 2;
      run_load(1'b0, 0, 0, 80);
      checks++; if (chain16 !== 16'h3CA5) begin errors++; $display("FAIL chain_contents got %h exp 3ca5", chain16); end
`ifdef CFG_READBACK_EN
      checks++; if (r_rb_cnt != 2) begin errors++; $display("FAIL rb_count got %0d exp 2", r_rb_cnt); end
      checks++; if (r_rb[0] !== 8'h34 || r_rb[1] !== 8'h12) begin errors++; $display("FAIL rb_words got %h %h exp 34 12", r_rb[0], r_rb[1]); end
`else
      checks++; if (r_rb_cnt != 0 || r_rb_any) begin errors++; $display("FAIL rb_disabled got pulses %0d nonzero %b exp 0 0", r_rb_cnt, r_rb_any); end
`endif
   endtask

   initial begin
      preload = 1'b0;
      a_start = 1'b0; a_abort = 1'b0; a_valid = 1'b0; a_data = '0;
      b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0; b_data = '0;
      test_reset();
      test_basic_load();
      test_partial_word();
      test_source_stall();
      test_reset_mid_shift();
      test_abort_start();
      test_readback();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
